joy_db15_tx: RTL



---
 rtl/joy_db15_pkg.sv | 23 ++
 rtl/joy_db15_edge_sync.sv | 64 ++++++
 rtl/joy_db15_tx.sv | 79 +++++++
 3 files changed

// File: rtl/joy_db15_pkg.sv
// Shared DB15 joystick definitions: pad word width, button bit positions and word type.
// Used by both the serial transmitter and the matching reader.
package joy_db15_pkg;

    localparam int DB15_BITS = 16;

    // Pad word layout, bit 0 first: R L D U A B C D E F S LB
    localparam int JOY_BIT_R  = 0;
    localparam int JOY_BIT_L  = 1;
    localparam int JOY_BIT_D  = 2;
    localparam int JOY_BIT_U  = 3;
    localparam int JOY_BIT_A  = 4;
    localparam int JOY_BIT_B  = 5;
    localparam int JOY_BIT_C  = 6;
    localparam int JOY_BIT_DB = 7;
    localparam int JOY_BIT_E  = 8;
    localparam int JOY_BIT_F  = 9;
    localparam int JOY_BIT_S  = 10;
    localparam int JOY_BIT_LB = 11;

    typedef logic [DB15_BITS-1:0] db15_word_t;

endpackage

// File: rtl/joy_db15_edge_sync.sv
// Synchronizer, optional 3-sample stability filter and rise/fall detector for one reader line.
// The filter is built only when JOY_DB15_TX_DEGLITCH_EN is defined.
module joy_db15_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   hist;

    // Lines idle high, so every flop resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef JOY_DB15_TX_DEGLITCH_EN
    logic [1:0] win;
    logic       filt;

    // The filtered level only moves once three consecutive samples agree.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win  <= '1;
            filt <= 1'b1;
        end else begin
            win <= {win[0], synced};
            if ({win, synced} == 3'b111) begin
                filt <= 1'b1;
            end else if ({win, synced} == 3'b000) begin
                filt <= 1'b0;
            end
        end
    end

    assign level = filt;
`else
    assign level = synced;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist <= 1'b1;
        end else begin
            hist <= level;
        end
    end

    assign rise = level & ~hist;
    assign fall = ~level & hist;

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 serial joystick link: two pads shifted out active-low, MSB first.
// Optional input deglitching is enabled with JOY_DB15_TX_DEGLITCH_EN.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int BITS        = DB15_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [BITS-1:0]          joystick1,
    input  logic [BITS-1:0]          joystick2,
    input  logic                     joy_load,
    input  logic                     joy_clk,
    output logic                     joy_data,
    output logic                     frame_strobe,
    output logic [$clog2(2*BITS):0]  bit_count,
    output logic                     overrun
);

    localparam int              CHAIN = 2 * BITS;
    localparam int              CW    = $clog2(CHAIN) + 1;
    localparam logic [CW-1:0]   FULL  = CW'(CHAIN);

    logic             load_level;
    logic             load_rise;
    logic             load_fall;
    logic             clk_level;
    logic             clk_rise;
    logic             clk_fall;
    logic [CHAIN-1:0] sr;
    logic             unused_edges;

    joy_db15_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_load),
        .level   (load_level),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    joy_db15_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_clk),
        .level   (clk_level),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    assign unused_edges = ^{load_rise, clk_level, clk_fall};

    // Load has priority over shift; the pads are re-sampled every cycle while load is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr           <= '1;
            bit_count    <= '0;
            overrun      <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= load_fall;
            if (!load_level) begin
                sr        <= ~{joystick1, joystick2};
                bit_count <= '0;
            end else if (clk_rise) begin
                sr <= {sr[CHAIN-2:0], 1'b1};
                if (bit_count == FULL) begin
                    overrun <= 1'b1;
                end else begin
                    bit_count <= bit_count + CW'(1);
                end
            end
        end
    end

    assign joy_data = sr[CHAIN-1];

endmodule
